// File: rtl/stack_context_unit_pkg.sv
// -----------------------------------------------------------------------------
// stack_context_unit_pkg
// Purpose : shared definitions for the stack context unit: default stack
//           pointer start value, default flag width, FSM state encodings and
//           operation codes recorded when a request is accepted.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package stack_context_unit_pkg;

  // Stack grows downward from here; a pop at this value is an underflow.
  localparam logic [31:0] SP_INIT_DEFAULT = 32'h000F_FFFF;
  localparam int          FLAGS_W_DEFAULT = 4;

  // Sequencer states
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_PUSH_F = 4'd1;
  localparam logic [3:0] ST_PUSH_H = 4'd2;
  localparam logic [3:0] ST_PUSH_L = 4'd3;
  localparam logic [3:0] ST_RD_L   = 4'd4;
  localparam logic [3:0] ST_RD_H   = 4'd5;
  localparam logic [3:0] ST_RD_F   = 4'd6;
  localparam logic [3:0] ST_WB_H   = 4'd7;
  localparam logic [3:0] ST_WB_F   = 4'd8;

  // Operation accepted in IDLE; only RET vs RTI matters after RD_H.
  localparam logic [1:0] OP_INT  = 2'd0;
  localparam logic [1:0] OP_CALL = 2'd1;
  localparam logic [1:0] OP_RET  = 2'd2;
  localparam logic [1:0] OP_RTI  = 2'd3;

endpackage

// File: rtl/stack_context_unit_stack_pointer.sv
// -----------------------------------------------------------------------------
// stack_pointer
// Purpose : owns the stack pointer register. Decrements on a push, increments
//           on a pop (modulo 2^32), and latches a sticky underflow fault when
//           a pop is issued while the pointer still sits at its start value.
// Ports   : clk, rst      clock and synchronous active-high reset
//           i_inc         pop this cycle (SP <= SP + 1)
//           i_dec         push this cycle (SP <= SP - 1)
//           o_sp          current stack pointer
//           o_spPlus1     address of the top-of-stack word for a pop
//           o_fault       sticky underflow flag
// -----------------------------------------------------------------------------
module stack_pointer
  import stack_context_unit_pkg::*;
#(
  parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_dec,
  output logic [31:0] o_sp,
  output logic [31:0] o_spPlus1,
  output logic        o_fault
);

  logic [31:0] r_sp;
  logic        r_fault;

  // Pointer update. The FSM never asks for inc and dec together, but inc
  // wins if it ever did. Wrap past either end of the address space is silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= SP_INIT;
    end else if (i_inc) begin
      r_sp <= r_sp + 32'd1;
    end else if (i_dec) begin
      r_sp <= r_sp - 32'd1;
    end
  end

  // Underflow is judged on the pointer value before the pop moves it, and
  // stays set until reset so software can find it after the fact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (i_inc && (r_sp == SP_INIT)) begin
      r_fault <= 1'b1;
    end
  end

  assign o_sp      = r_sp;
  assign o_spPlus1 = r_sp + 32'd1;
  assign o_fault   = r_fault;

endmodule

// File: rtl/stack_context_unit.sv
// -----------------------------------------------------------------------------
// stack_context_unit
// Purpose : memory-stage responder that saves PC (two 16-bit halves) and
//           flags to the data-memory stack on interrupt entry / CALL, and
//           restores them on RET / RTI, strobing the fetch PC halves and the
//           flag register. Holds the pipeline with busy while sequencing.
// Ports   : clk, rst                      clock, synchronous active-high reset
//           push_flags_pc, call_req,      request pulses, accepted only in
//           ret_req, rti_req              IDLE (rti > ret > int > call)
//           pc_in, flags_in               context captured on accept
//           mem_rdata                     read data, one cycle after mem_read
//           mem_addr, mem_wdata,          stack memory access
//           mem_write, mem_read
//           return_address,               restored PC half and which half
//           write_pc_low, write_pc_high
//           flags_out, write_flags        restored flags and load strobe
//           busy, sp, stack_fault         status
// -----------------------------------------------------------------------------
module stack_context_unit
  import stack_context_unit_pkg::*;
#(
  parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT,
  parameter int          FLAGS_W = FLAGS_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_flags_pc,
  input  logic               call_req,
  input  logic               ret_req,
  input  logic               rti_req,
  input  logic [31:0]        pc_in,
  input  logic [FLAGS_W-1:0] flags_in,
  input  logic [15:0]        mem_rdata,
  output logic [31:0]        mem_addr,
  output logic [15:0]        mem_wdata,
  output logic               mem_write,
  output logic               mem_read,
  output logic [15:0]        return_address,
  output logic               write_pc_low,
  output logic               write_pc_high,
  output logic [FLAGS_W-1:0] flags_out,
  output logic               write_flags,
  output logic               busy,
  output logic [31:0]        sp,
  output logic               stack_fault
);

  logic [3:0]         r_state;
  logic [1:0]         r_op;
  logic [31:0]        r_pc;
  logic [FLAGS_W-1:0] r_flags;

  logic [3:0]  w_stateNext;
  logic        w_accept;
  logic [1:0]  w_acceptOp;
  logic        w_pushing;
  logic        w_popRead;
  logic [31:0] w_sp;
  logic [31:0] w_spPlus1;
  logic        w_fault;

  assign w_pushing = (r_state == ST_PUSH_F) || (r_state == ST_PUSH_H) ||
                     (r_state == ST_PUSH_L);
  assign w_popRead = (r_state == ST_RD_L) || (r_state == ST_RD_H) ||
                     (r_state == ST_RD_F);

  stack_pointer #(
    .SP_INIT (SP_INIT)
  ) u_stackPointer (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (w_popRead),
    .i_dec     (w_pushing),
    .o_sp      (w_sp),
    .o_spPlus1 (w_spPlus1),
    .o_fault   (w_fault)
  );

  // Request arbitration. Only meaningful in IDLE; anything raised while a
  // sequence is running, or losing to a higher-priority request, is dropped.
  always_comb begin
    w_accept   = 1'b1;
    w_acceptOp = OP_CALL;
    if (rti_req) begin
      w_acceptOp = OP_RTI;
    end else if (ret_req) begin
      w_acceptOp = OP_RET;
    end else if (push_flags_pc) begin
      w_acceptOp = OP_INT;
    end else if (call_req) begin
      w_acceptOp = OP_CALL;
    end else begin
      w_accept = 1'b0;
    end
  end

  // Sequencer. Each state is exactly one cycle; the only branch after
  // accept is RD_H, where RTI goes on to fetch the flags word.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_acceptOp)
            OP_INT:  w_stateNext = ST_PUSH_F;
            OP_CALL: w_stateNext = ST_PUSH_H;
            default: w_stateNext = ST_RD_L;
          endcase
        end
      end
      ST_PUSH_F: w_stateNext = ST_PUSH_H;
      ST_PUSH_H: w_stateNext = ST_PUSH_L;
      ST_PUSH_L: w_stateNext = ST_IDLE;
      ST_RD_L:   w_stateNext = ST_RD_H;
      ST_RD_H:   w_stateNext = (r_op == OP_RTI) ? ST_RD_F : ST_WB_H;
      ST_RD_F:   w_stateNext = ST_WB_F;
      ST_WB_H:   w_stateNext = ST_IDLE;
      ST_WB_F:   w_stateNext = ST_IDLE;
      default:   w_stateNext = ST_IDLE;
    endcase
  end

  // State and context capture. PC and flags are frozen at accept so that
  // fetch may move on while the words are still being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_INT;
      r_pc    <= 32'd0;
      r_flags <= '0;
    end else begin
      r_state <= w_stateNext;
      if ((r_state == ST_IDLE) && w_accept) begin
        r_op    <= w_acceptOp;
        r_pc    <= pc_in;
        r_flags <= flags_in;
      end
    end
  end

  // Push data per state; flags are zero-extended into a full stack word.
  always_comb begin
    mem_wdata = 16'd0;
    case (r_state)
      ST_PUSH_F: mem_wdata = {{(16-FLAGS_W){1'b0}}, r_flags};
      ST_PUSH_H: mem_wdata = r_pc[31:16];
      ST_PUSH_L: mem_wdata = r_pc[15:0];
      default:   mem_wdata = 16'd0;
    endcase
  end

  // Moore output decode. A read state's data arrives in the following
  // state, so each PC/flag strobe lags its read by one cycle.
  assign mem_write      = w_pushing;
  assign mem_read       = w_popRead;
  assign mem_addr       = w_pushing ? w_sp : (w_popRead ? w_spPlus1 : 32'd0);
  assign write_pc_low   = (r_state == ST_RD_H);
  assign write_pc_high  = (r_state == ST_RD_F) || (r_state == ST_WB_H);
  assign write_flags    = (r_state == ST_WB_F);
  assign return_address = (write_pc_low || write_pc_high) ? mem_rdata : 16'd0;
  assign flags_out      = mem_rdata[FLAGS_W-1:0];
  assign busy           = (r_state != ST_IDLE);
  assign sp             = w_sp;
  assign stack_fault    = w_fault;

endmodule

// File: tb/tb_stack_context_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_context_unit
// Purpose : self-checking bench for stack_context_unit. A behavioural model
//           turns each accepted request into the list of per-cycle outputs
//           the unit must show; a compare process checks them every cycle,
//           and directed tests pin the results with hand-computed values.
// -----------------------------------------------------------------------------
module tb_stack_context_unit;

  localparam logic [31:0] SP_INIT = 32'h000F_FFFF;

  typedef struct {
    logic        busy;
    logic        wr;
    logic        rd;
    logic        wrLo;
    logic        wrHi;
    logic        wrFl;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [15:0] ret;
    logic [3:0]  fl;
    logic [31:0] sp;
    logic        fault;
  } expRec_t;

  logic        clk;
  logic        rst;
  logic        push_flags_pc;
  logic        call_req;
  logic        ret_req;
  logic        rti_req;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic [15:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] return_address;
  logic        write_pc_low;
  logic        write_pc_high;
  logic [3:0]  flags_out;
  logic        write_flags;
  logic        busy;
  logic [31:0] sp;
  logic        stack_fault;

  int passCount = 0;
  int checkCount = 0;

  logic [15:0] benchMem [logic [31:0]];
  logic [15:0] modelMem [logic [31:0]];
  expRec_t     expQ [$];
  logic [31:0] modelSp = SP_INIT;
  logic        modelFault = 1'b0;
  bit          modelIdle = 1'b1;
  bit          checkEnable = 1'b0;

  logic [15:0] lastLo = 16'hDEAD;
  logic [15:0] lastHi = 16'hDEAD;
  logic [3:0]  lastFlags = 4'hF;
  int          busyCount = 0;

  stack_context_unit dut (
    .clk            (clk),
    .rst            (rst),
    .push_flags_pc  (push_flags_pc),
    .call_req       (call_req),
    .ret_req        (ret_req),
    .rti_req        (rti_req),
    .pc_in          (pc_in),
    .flags_in       (flags_in),
    .mem_rdata      (mem_rdata),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .return_address (return_address),
    .write_pc_low   (write_pc_low),
    .write_pc_high  (write_pc_high),
    .flags_out      (flags_out),
    .write_flags    (write_flags),
    .busy           (busy),
    .sp             (sp),
    .stack_fault    (stack_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic logic [15:0] readWord(input logic [31:0] a, input bit fromModel);
    if (fromModel) return modelMem.exists(a) ? modelMem[a] : 16'h0000;
    return benchMem.exists(a) ? benchMem[a] : 16'h0000;
  endfunction

  function automatic expRec_t blankRec(input logic [31:0] s, input logic f);
    expRec_t r;
    r.busy = 0; r.wr = 0; r.rd = 0; r.wrLo = 0; r.wrHi = 0; r.wrFl = 0;
    r.addr = 32'h0; r.wdata = 16'h0; r.ret = 16'h0; r.fl = 4'h0;
    r.sp = s; r.fault = f;
    return r;
  endfunction

  // Data memory: writes land at the edge, reads return one cycle later.
  always @(posedge clk) begin
    if (mem_write === 1'b1) benchMem[mem_addr] = mem_wdata;
    if (mem_read === 1'b1) mem_rdata <= readWord(mem_addr, 1'b0);
    else mem_rdata <= 16'h0000;
  end

  // Model: one push per cycle, each going to SP then SP-1.
  task automatic genPush(input bit withFlags, input logic [31:0] pc, input logic [3:0] fl);
    logic [15:0] words [$];
    expRec_t r;
    if (withFlags) words.push_back({12'h000, fl});
    words.push_back(pc[31:16]);
    words.push_back(pc[15:0]);
    foreach (words[i]) begin
      r = blankRec(modelSp, modelFault);
      r.busy = 1; r.wr = 1; r.addr = modelSp; r.wdata = words[i];
      expQ.push_back(r);
      modelSp = modelSp - 32'd1;
    end
  endtask

  // Model: pops read SP+1 then bump SP; each word is delivered to fetch
  // one cycle after it was read. RTI reads a third word for the flags.
  task automatic genPop(input bit isRti);
    logic [15:0] got [3];
    expRec_t r;
    int nReads;
    nReads = isRti ? 3 : 2;
    for (int i = 0; i < nReads; i++) begin
      r = blankRec(modelSp, modelFault);
      r.busy = 1; r.rd = 1; r.addr = modelSp + 32'd1;
      if (i == 1) begin r.wrLo = 1; r.ret = got[0]; end
      if (i == 2) begin r.wrHi = 1; r.ret = got[1]; end
      expQ.push_back(r);
      if (modelSp == SP_INIT) modelFault = 1'b1;
      modelSp = modelSp + 32'd1;
      got[i] = readWord(modelSp, 1'b1);
    end
    r = blankRec(modelSp, modelFault);
    r.busy = 1;
    if (isRti) begin r.wrFl = 1; r.fl = got[2][3:0]; end
    else begin r.wrHi = 1; r.ret = got[1]; end
    expQ.push_back(r);
  endtask

  // Model acceptance: only from a cycle the model considers idle.
  always @(posedge clk) begin
    if (rst) begin
      expQ.delete();
      modelSp = SP_INIT;
      modelFault = 1'b0;
    end else if (modelIdle) begin
      if (rti_req) genPop(1'b1);
      else if (ret_req) genPop(1'b0);
      else if (push_flags_pc) genPush(1'b1, pc_in, flags_in);
      else if (call_req) genPush(1'b0, pc_in, 4'h0);
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    expRec_t e;
    if (checkEnable) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        modelIdle = 1'b0;
        if (e.wr) modelMem[e.addr] = e.wdata;
      end else begin
        e = blankRec(modelSp, modelFault);
        modelIdle = 1'b1;
      end
      checkOutput("busy", {31'h0, busy}, {31'h0, e.busy});
      checkOutput("mem_write", {31'h0, mem_write}, {31'h0, e.wr});
      checkOutput("mem_read", {31'h0, mem_read}, {31'h0, e.rd});
      if (e.wr || e.rd) checkOutput("mem_addr", mem_addr, e.addr);
      if (e.wr) checkOutput("mem_wdata", {16'h0, mem_wdata}, {16'h0, e.wdata});
      checkOutput("write_pc_low", {31'h0, write_pc_low}, {31'h0, e.wrLo});
      checkOutput("write_pc_high", {31'h0, write_pc_high}, {31'h0, e.wrHi});
      checkOutput("return_address", {16'h0, return_address}, {16'h0, e.ret});
      checkOutput("write_flags", {31'h0, write_flags}, {31'h0, e.wrFl});
      if (e.wrFl) checkOutput("flags_out", {28'h0, flags_out}, {28'h0, e.fl});
      checkOutput("sp", sp, e.sp);
      checkOutput("stack_fault", {31'h0, stack_fault}, {31'h0, e.fault});
    end
  end

  // Record the most recent restored values for the directed checks.
  always @(negedge clk) begin
    if (write_pc_low === 1'b1) lastLo = return_address;
    if (write_pc_high === 1'b1) lastHi = return_address;
    if (write_flags === 1'b1) lastFlags = flags_out;
    if (busy === 1'b1) busyCount++;
  end

  // Drive one request pulse for exactly one sampling edge.
  task automatic applyStimulus(input logic iRti, input logic iRet, input logic iInt,
                               input logic iCall, input logic [31:0] iPc, input logic [3:0] iFlags);
    rti_req = iRti; ret_req = iRet; push_flags_pc = iInt; call_req = iCall;
    pc_in = iPc; flags_in = iFlags;
    @(posedge clk); #1;
    rti_req = 0; ret_req = 0; push_flags_pc = 0; call_req = 0;
    pc_in = 32'h0; flags_in = 4'h0;
  endtask

  task automatic waitIdle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy === 1'b0) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) checkOutput({name, "_timeout"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int busyStart;
    rst = 1; push_flags_pc = 0; call_req = 0; ret_req = 0; rti_req = 0;
    pc_in = 32'h0; flags_in = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    checkEnable = 1;

    // Test 1: reset state
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("t1_sp", sp, 32'h000F_FFFF);
    checkOutput("t1_busy", {31'h0, busy}, 32'h0);
    checkOutput("t1_fault", {31'h0, stack_fault}, 32'h0);
    checkOutput("t1_strobes", {27'h0, mem_write, mem_read, write_pc_low, write_pc_high, write_flags}, 32'h0);
    checkOutput("t1_addr", mem_addr, 32'h0);
    checkOutput("t1_wdata", {16'h0, mem_wdata}, 32'h0);

    // Test 2: interrupt entry
    busyStart = busyCount;
    applyStimulus(0, 0, 1, 0, 32'h0001_2345, 4'b0101);
    waitIdle("t2");
    checkOutput("t2_sp", sp, 32'h000F_FFFC);
    checkOutput("t2_model_sp", modelSp, 32'h000F_FFFC);
    checkOutput("t2_mem_fffff", {16'h0, readWord(32'h000F_FFFF, 0)}, 32'h0005);
    checkOutput("t2_mem_ffffe", {16'h0, readWord(32'h000F_FFFE, 0)}, 32'h0001);
    checkOutput("t2_mem_ffffd", {16'h0, readWord(32'h000F_FFFD, 0)}, 32'h2345);
    checkOutput("t2_busy_cycles", busyCount - busyStart, 32'd3);

    // Test 3: RTI restores the interrupt context
    busyStart = busyCount;
    applyStimulus(1, 0, 0, 0, 32'h0, 4'h0);
    waitIdle("t3");
    checkOutput("t3_lo", {16'h0, lastLo}, 32'h2345);
    checkOutput("t3_hi", {16'h0, lastHi}, 32'h0001);
    checkOutput("t3_flags", {28'h0, lastFlags}, 32'h5);
    checkOutput("t3_sp", sp, 32'h000F_FFFF);
    checkOutput("t3_fault", {31'h0, stack_fault}, 32'h0);
    checkOutput("t3_busy_cycles", busyCount - busyStart, 32'd4);

    // Test 4: CALL then RET
    applyStimulus(0, 0, 0, 1, 32'hABCD_0010, 4'h0);
    waitIdle("t4c");
    checkOutput("t4_mem_fffff", {16'h0, readWord(32'h000F_FFFF, 0)}, 32'hABCD);
    checkOutput("t4_mem_ffffe", {16'h0, readWord(32'h000F_FFFE, 0)}, 32'h0010);
    checkOutput("t4_sp_call", sp, 32'h000F_FFFD);
    applyStimulus(0, 1, 0, 0, 32'h0, 4'h0);
    waitIdle("t4r");
    checkOutput("t4_lo", {16'h0, lastLo}, 32'h0010);
    checkOutput("t4_hi", {16'h0, lastHi}, 32'hABCD);
    checkOutput("t4_sp", sp, 32'h000F_FFFF);

    // Test 5: priority and requests while busy
    applyStimulus(0, 0, 1, 1, 32'h1111_2222, 4'hA);
    waitIdle("t5i");
    checkOutput("t5_int_wins_sp", sp, 32'h000F_FFFC);
    checkOutput("t5_int_wins_mem", {16'h0, readWord(32'h000F_FFFF, 0)}, 32'h000A);
    applyStimulus(1, 0, 1, 0, 32'h5555_6666, 4'h3);
    applyStimulus(0, 0, 0, 1, 32'h7777_8888, 4'h0);
    waitIdle("t5r");
    checkOutput("t5_lo", {16'h0, lastLo}, 32'h2222);
    checkOutput("t5_hi", {16'h0, lastHi}, 32'h1111);
    checkOutput("t5_flags", {28'h0, lastFlags}, 32'hA);
    checkOutput("t5_sp", sp, 32'h000F_FFFF);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("t5_sp_after", sp, 32'h000F_FFFF);

    // Test 6: underflow fault, then reset in the middle of a push
    applyStimulus(0, 1, 0, 0, 32'h0, 4'h0);
    waitIdle("t6");
    checkOutput("t6_fault", {31'h0, stack_fault}, 32'h1);
    checkOutput("t6_sp", sp, 32'h0010_0001);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("t6_fault_sticky", {31'h0, stack_fault}, 32'h1);
    applyStimulus(0, 0, 1, 0, 32'h0BAD_0BAD, 4'h6);
    @(posedge clk); #1;
    checkOutput("t6_in_push_h", {16'h0, mem_wdata}, 32'h0BAD);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checkOutput("t6_rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("t6_rst_sp", sp, 32'h000F_FFFF);
    checkOutput("t6_rst_fault", {31'h0, stack_fault}, 32'h0);
    checkOutput("t6_rst_write", {31'h0, mem_write}, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("t6_rst_quiet", {28'h0, mem_write, mem_read, write_pc_low, write_pc_high}, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
